// File: rtl/gen_fip_sign_mult_seq.sv
// Multi-cycle signed fixed-point multiplier.
//
// Multiplies a signed Q(N1_INT_W).(N1_FRACT_W) multiplicand by a signed
// Q(N2_INT_W).(N2_FRACT_W) multiplier, consuming STEP_W multiplier bits per
// cycle, then converts the exact product to Q(RES_INT_W).(RES_FRACT_W) with
// truncation or round-half-up and saturating or wrapping overflow.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   i_start_pls one-cycle start pulse; operands sampled in the same cycle
//   i_num1      signed fixed-point multiplicand
//   i_num2      signed fixed-point multiplier
//   o_busy      operation in progress (start cycle + 1 through done cycle)
//   o_done_pls  one-cycle pulse; o_res/o_ovf_flag valid from this cycle
//   o_res       formatted product, held until the next done
//   o_ovf_flag  formatted value differs from the exact (rounded) product
module gen_fip_sign_mult_seq #(
  parameter int unsigned N1_INT_W    = 1,
  parameter int unsigned N1_FRACT_W  = 5,
  parameter int unsigned N2_INT_W    = 1,
  parameter int unsigned N2_FRACT_W  = 5,
  parameter int unsigned RES_INT_W   = N1_INT_W + N2_INT_W,
  parameter int unsigned RES_FRACT_W = N1_FRACT_W + N2_FRACT_W,
  parameter int unsigned STEP_W      = 1,
  parameter int unsigned ROUND_MODE  = 0,
  parameter int unsigned SAT_EN      = 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_start_pls,
  input  logic [N1_INT_W+N1_FRACT_W-1:0]      i_num1,
  input  logic [N2_INT_W+N2_FRACT_W-1:0]      i_num2,
  output logic                                o_busy,
  output logic                                o_done_pls,
  output logic [RES_INT_W+RES_FRACT_W-1:0]    o_res,
  output logic                                o_ovf_flag
);

  localparam int unsigned N1_W    = N1_INT_W + N1_FRACT_W;
  localparam int unsigned N2_W    = N2_INT_W + N2_FRACT_W;
  localparam int unsigned RES_W   = RES_INT_W + RES_FRACT_W;
  localparam int unsigned ITER    = (N2_W + STEP_W - 1) / STEP_W;
  // Multiplier register is padded to a whole number of chunks.
  localparam int unsigned M2_W    = ITER * STEP_W;
  localparam int unsigned PW      = N1_W + N2_W;
  localparam int unsigned P_INT   = N1_INT_W + N2_INT_W;
  localparam int unsigned P_FRACT = N1_FRACT_W + N2_FRACT_W;
  // Product re-aligned to the result fraction, with one spare integer bit
  // so a rounding carry cannot be lost before the range check.
  localparam int unsigned V_W     = P_INT + 1 + RES_FRACT_W;
  localparam int unsigned CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {StIdle, StMult, StFmt} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      mcand_q;
  logic [M2_W-1:0]    mplier_q;
  logic [PW-1:0]      acc_q;
  logic               busy_q;
  logic               done_q;
  logic [RES_W-1:0]   res_q;
  logic               ovf_q;

  logic               last_chunk;
  logic [STEP_W-1:0]  chunk;
  logic [STEP_W:0]    chunk_ext;
  logic [PW-1:0]      pp;
  logic [PW-1:0]      acc_nxt;
  logic [V_W-1:0]     fmt_v;
  logic [RES_W-1:0]   res_fmt;
  logic               ovf_fmt;

  // ---------------------------------------------------------------------------
  // Partial product datapath
  // ---------------------------------------------------------------------------
  assign last_chunk = (cnt_q == CNT_W'(ITER - 1));
  assign chunk      = mplier_q[STEP_W-1:0];
  // Lower chunks are unsigned digits; the top chunk carries the sign weight.
  assign chunk_ext  = {last_chunk & chunk[STEP_W-1], chunk};
  // Modular PW-bit product is exact: the full signed product always fits.
  assign pp         = mcand_q * PW'($signed(chunk_ext));
  assign acc_nxt    = acc_q + pp;

  // ---------------------------------------------------------------------------
  // Fraction conversion of the final accumulator value
  // ---------------------------------------------------------------------------
  if (RES_FRACT_W >= P_FRACT) begin : g_frac_ext
    assign fmt_v = V_W'($signed(acc_nxt)) << (RES_FRACT_W - P_FRACT);
  end else begin : g_frac_drop
    localparam int unsigned D = P_FRACT - RES_FRACT_W;
    logic rnd_bit;
    // Round half up: floor(x + half LSB) == floor(x) + first dropped bit.
    assign rnd_bit = (ROUND_MODE != 0) ? acc_nxt[D-1] : 1'b0;
    assign fmt_v   = V_W'($signed(acc_nxt[PW-1:D])) + {{(V_W-1){1'b0}}, rnd_bit};
  end

  // ---------------------------------------------------------------------------
  // Integer conversion with overflow detection
  // ---------------------------------------------------------------------------
  if (RES_INT_W > P_INT) begin : g_int_ext
    assign res_fmt = RES_W'($signed(fmt_v));
    assign ovf_fmt = 1'b0;
  end else begin : g_int_chk
    logic [V_W-RES_W:0] top;
    logic [RES_W-1:0]   sat_max;
    logic [RES_W-1:0]   sat_min;
    // In range iff every bit from the result sign bit upward is identical.
    assign top     = fmt_v[V_W-1:RES_W-1];
    assign ovf_fmt = ~((&top) | ~(|top));
    assign sat_max = {RES_W{1'b1}} >> 1;
    assign sat_min = ~sat_max;
    assign res_fmt = (ovf_fmt && (SAT_EN != 0)) ? (fmt_v[V_W-1] ? sat_min : sat_max)
                                                : fmt_v[RES_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  // The last MULT edge both folds in the final partial product and registers
  // the formatted result, so o_res is already valid during the FMT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start_pls) begin
            mcand_q  <= PW'($signed(i_num1));
            mplier_q <= M2_W'($signed(i_num2));
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StMult;
          end
        end
        StMult: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << STEP_W;
          mplier_q <= mplier_q >> STEP_W;
          if (last_chunk) begin
            cnt_q   <= '0;
            res_q   <= res_fmt;
            ovf_q   <= ovf_fmt;
            done_q  <= 1'b1;
            state_q <= StFmt;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StFmt: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done_pls = done_q;
  assign o_res      = res_q;
  assign o_ovf_flag = ovf_q;

endmodule

// File: tb/tb_gen_fip_sign_mult_seq.sv
// Bench for gen_fip_sign_mult_seq: six parameterisations share one stimulus.
//   u0 defaults (Q1.5 x Q1.5 -> Q2.10, STEP_W=1)
//   u1 defaults with STEP_W=4 (ITER=2)
//   u2 Q1.5 result, saturating;  u3 Q1.5 result, wrapping
//   u4 Q2.5 result, truncate;    u5 Q2.5 result, round half up
module tb_gen_fip_sign_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       start;
  logic [5:0] num1;
  logic [5:0] num2;

  logic       busy_v [6];
  logic       done_v [6];
  logic       ovf_v  [6];
  logic [11:0] res0, res1;
  logic [5:0]  res2, res3;
  logic [6:0]  res4, res5;

  int n_chk  = 0;
  int n_fail = 0;

  gen_fip_sign_mult_seq u0 (
    .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num1(num1), .i_num2(num2),
    .o_busy(busy_v[0]), .o_done_pls(done_v[0]), .o_res(res0), .o_ovf_flag(ovf_v[0]));

  gen_fip_sign_mult_seq #(.STEP_W(4)) u1 (
    .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num1(num1), .i_num2(num2),
    .o_busy(busy_v[1]), .o_done_pls(done_v[1]), .o_res(res1), .o_ovf_flag(ovf_v[1]));

  gen_fip_sign_mult_seq #(.RES_INT_W(1), .RES_FRACT_W(5), .SAT_EN(1)) u2 (
    .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num1(num1), .i_num2(num2),
    .o_busy(busy_v[2]), .o_done_pls(done_v[2]), .o_res(res2), .o_ovf_flag(ovf_v[2]));

  gen_fip_sign_mult_seq #(.RES_INT_W(1), .RES_FRACT_W(5), .SAT_EN(0)) u3 (
    .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num1(num1), .i_num2(num2),
    .o_busy(busy_v[3]), .o_done_pls(done_v[3]), .o_res(res3), .o_ovf_flag(ovf_v[3]));

  gen_fip_sign_mult_seq #(.RES_INT_W(2), .RES_FRACT_W(5), .ROUND_MODE(0)) u4 (
    .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num1(num1), .i_num2(num2),
    .o_busy(busy_v[4]), .o_done_pls(done_v[4]), .o_res(res4), .o_ovf_flag(ovf_v[4]));

  gen_fip_sign_mult_seq #(.RES_INT_W(2), .RES_FRACT_W(5), .ROUND_MODE(1)) u5 (
    .clk(clk), .rstn(rstn), .i_start_pls(start), .i_num1(num1), .i_num2(num2),
    .o_busy(busy_v[5]), .o_done_pls(done_v[5]), .o_res(res5), .o_ovf_flag(ovf_v[5]));

  typedef struct {
    logic [5:0]  n1;
    logic [5:0]  n2;
    logic [11:0] e_full;  // exact Q2.10 product (u0, u1)
    logic [5:0]  e_sat;   // u2
    logic [5:0]  e_wrap;  // u3
    logic        e_ovf;   // u2 and u3
    logic [6:0]  e_r0;    // u4
    logic [6:0]  e_r1;    // u5
  } vec_t;

  vec_t vecs [10];

  // Per-operation capture
  int          dcyc [6];
  int          dcnt [6];
  logic [11:0] cres [6];
  logic        covf [6];
  logic        busy_bad;
  logic        hold_bad;

  function automatic logic [11:0] res_of(input int i);
    case (i)
      0: return res0;
      1: return res1;
      2: return {6'd0, res2};
      3: return {6'd0, res3};
      4: return {5'd0, res4};
      5: return {5'd0, res5};
      default: return 12'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start pulse in cycle 0, then observe cycles 1..20.
  task automatic do_op(input logic [5:0] n1, input logic [5:0] n2);
    logic [11:0] prev0;
    prev0    = res0;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dcyc[i] = -1;
      dcnt[i] = 0;
    end
    @(negedge clk);
    num1  = n1;
    num2  = n2;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (busy_v[0] !== (k <= 7)) busy_bad = 1'b1;
      if (busy_v[1] !== (k <= 3)) busy_bad = 1'b1;
      if (k < 7 && res0 !== prev0) hold_bad = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (done_v[i] === 1'b1) begin
          dcnt[i]++;
          if (dcyc[i] < 0) begin
            dcyc[i] = k;
            cres[i] = res_of(i);
            covf[i] = ovf_v[i];
          end
        end
      end
    end
  endtask

  int          d0_cyc [4];
  logic [11:0] d0_res [4];
  int          d1_cyc [4];
  logic [11:0] d1_res [4];
  int          n0, n1d, nd;

  initial begin
    vecs[0] = '{6'h10, 6'h30, 12'hF00, 6'h38, 6'h38, 1'b0, 7'h78, 7'h78};
    vecs[1] = '{6'h20, 6'h20, 12'h400, 6'h1F, 6'h20, 1'b1, 7'h20, 7'h20};
    vecs[2] = '{6'h01, 6'h10, 12'h010, 6'h00, 6'h00, 1'b0, 7'h00, 7'h01};
    vecs[3] = '{6'h3F, 6'h10, 12'hFF0, 6'h3F, 6'h3F, 1'b0, 7'h7F, 7'h00};
    vecs[4] = '{6'h1F, 6'h1F, 12'h3C1, 6'h1E, 6'h1E, 1'b0, 7'h1E, 7'h1E};
    vecs[5] = '{6'h20, 6'h1F, 12'hC20, 6'h21, 6'h21, 1'b0, 7'h61, 7'h61};
    vecs[6] = '{6'h15, 6'h2B, 12'hE47, 6'h32, 6'h32, 1'b0, 7'h72, 7'h72};
    vecs[7] = '{6'h0B, 6'h05, 12'h037, 6'h01, 6'h01, 1'b0, 7'h01, 7'h02};
    vecs[8] = '{6'h00, 6'h20, 12'h000, 6'h00, 6'h00, 1'b0, 7'h00, 7'h00};
    vecs[9] = '{6'h20, 6'h01, 12'hFE0, 6'h3F, 6'h3F, 1'b0, 7'h7F, 7'h7F};

    // Reset state
    rstn  = 1'b0;
    start = 1'b0;
    num1  = '0;
    num2  = '0;
    #1;
    for (int i = 0; i < 6; i++)
      chk($sformatf("reset_u%0d", i), {busy_v[i], done_v[i], ovf_v[i], res_of(i)}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Table-driven vectors
    for (int j = 0; j < 10; j++) begin
      do_op(vecs[j].n1, vecs[j].n2);
      chk($sformatf("v%0d_u0_res", j), cres[0], vecs[j].e_full);
      chk($sformatf("v%0d_u0_ovf", j), covf[0], 1'b0);
      chk($sformatf("v%0d_u1_res", j), cres[1], vecs[j].e_full);
      chk($sformatf("v%0d_u2_res", j), cres[2], vecs[j].e_sat);
      chk($sformatf("v%0d_u2_ovf", j), covf[2], vecs[j].e_ovf);
      chk($sformatf("v%0d_u3_res", j), cres[3], vecs[j].e_wrap);
      chk($sformatf("v%0d_u3_ovf", j), covf[3], vecs[j].e_ovf);
      chk($sformatf("v%0d_u4_res", j), cres[4], vecs[j].e_r0);
      chk($sformatf("v%0d_u5_res", j), cres[5], vecs[j].e_r1);
      chk($sformatf("v%0d_u45_ovf", j), {covf[4], covf[5]}, 2'b00);
      for (int i = 0; i < 6; i++)
        chk($sformatf("v%0d_u%0d_done_cycle", j, i), dcyc[i], (i == 1) ? 3 : 7);
      chk($sformatf("v%0d_u0_done_count", j), dcnt[0], 1);
      chk($sformatf("v%0d_busy_window", j), busy_bad, 1'b0);
      chk($sformatf("v%0d_res_hold", j), hold_bad, 1'b0);
    end

    // Starts while busy are ignored; first cycle after done is accepted.
    n0  = 0;
    n1d = 0;
    for (int i = 0; i < 4; i++) begin
      d0_cyc[i] = -1;
      d1_cyc[i] = -1;
      d0_res[i] = '0;
      d1_res[i] = '0;
    end
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      start = (k == 0 || k == 3 || k == 7 || k == 8);
      if (k == 0) begin
        num1 = 6'h10; num2 = 6'h30;
      end else if (k == 3 || k == 7) begin
        num1 = 6'h1F; num2 = 6'h1F;
      end else if (k == 8) begin
        num1 = 6'h20; num2 = 6'h20;
      end
      @(posedge clk);
      #1;
      if (done_v[0] === 1'b1) begin
        if (n0 < 4) begin d0_cyc[n0] = k + 1; d0_res[n0] = res0; end
        n0++;
      end
      if (done_v[1] === 1'b1) begin
        if (n1d < 4) begin d1_cyc[n1d] = k + 1; d1_res[n1d] = res1; end
        n1d++;
      end
    end
    chk("ovl_u0_done_count", n0, 2);
    chk("ovl_u0_first_cycle", d0_cyc[0], 7);
    chk("ovl_u0_first_res", d0_res[0], 12'hF00);
    chk("ovl_u0_second_cycle", d0_cyc[1], 15);
    chk("ovl_u0_second_res", d0_res[1], 12'h400);
    chk("ovl_u1_done_count", n1d, 2);
    chk("ovl_u1_first_cycle", d1_cyc[0], 3);
    chk("ovl_u1_first_res", d1_res[0], 12'hF00);
    chk("ovl_u1_second_cycle", d1_cyc[1], 10);
    chk("ovl_u1_second_res", d1_res[1], 12'h3C1);

    // Reset in the middle of an operation
    @(negedge clk);
    num1  = 6'h10;
    num2  = 6'h30;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_u0_busy", busy_v[0], 1'b0);
    chk("abort_u0_res", res0, 12'h000);
    chk("abort_u0_ovf", ovf_v[0], 1'b0);
    chk("abort_u0_done", done_v[0], 1'b0);
    chk("abort_u1_res", res1, 12'h000);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++)
        if (done_v[i] === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    do_op(6'h15, 6'h2B);
    chk("post_abort_u0_res", cres[0], 12'hE47);
    chk("post_abort_u0_cycle", dcyc[0], 7);
    chk("post_abort_u4_res", cres[4], 7'h72);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_fip_sign_mult_seq.md
Name: gen_fip_sign_mult_seq

Overview:
Multi-cycle signed fixed-point multiplier, the sequential successor of the single-cycle combinational multiplier in gen_componentes/fixed_point_arithmetic.
- Operands may differ in integer and fraction widths.
- The multiplier array is narrowed to STEP_W partial-product bits per cycle.
- The product is converted to an arbitrary result format with a selectable rounding mode and saturating or wrapping overflow, plus an overflow flag.
- Used where a full-width array multiplier does not meet area or timing (e.g., accumulators in iterative datapaths).

Parameters:
N1_INT_W, 1, num1 integer bits incl. sign (>=1)
N1_FRACT_W, 5, num1 fraction bits (>=0)
N2_INT_W, 1, num2 integer bits incl. sign (>=1)
N2_FRACT_W, 5, num2 fraction bits (>=0)
RES_INT_W, N1_INT_W+N2_INT_W, result integer bits incl. sign (>=1)
RES_FRACT_W, N1_FRACT_W+N2_FRACT_W, result fraction bits (>=0)
STEP_W, 1, num2 bits consumed per iteration (1..N2_W)
ROUND_MODE, 0, 0 = truncate toward -inf, 1 = round half up (add 2^-(RES_FRACT_W+1), then floor)
SAT_EN, 1, 1 = saturate on integer overflow, 0 = wrap (drop MSBs)
Local, not user-set: N1_W=N1_INT_W+N1_FRACT_W; N2_W=N2_INT_W+N2_FRACT_W; RES_W=RES_INT_W+RES_FRACT_W; ITER=ceil(N2_W/STEP_W)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
i_start_pls  input  1  one-cycle start pulse; operands sampled in the same cycle
i_num1  input  N1_W  signed fixed-point multiplicand
i_num2  input  N2_W  signed fixed-point multiplier
o_busy  output  1  operation in progress
o_done_pls  output  1  one-cycle pulse; o_res and o_ovf_flag are valid this cycle
o_res  output  RES_W  formatted product, signed fixed-point; held until the next done
o_ovf_flag  output  1  formatted value differs from the exact (rounded) product; held with o_res

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; o_busy=0, o_done_pls=0, o_res=0, o_ovf_flag=0; all internal registers cleared.
- Reset mid-operation: the operation is aborted and no o_done_pls is produced.
- Exact product: width N1_W+N2_W, INT=N1_INT_W+N2_INT_W, FRACT=N1_FRACT_W+N2_FRACT_W. It must be bit-exact two's-complement; -min*-min is included.
- Iteration:
  - num1 is sign-extended to the full product width.
  - num2 is consumed LSB-first, STEP_W bits per cycle.
  - The final (most-significant) chunk carries negative weight on its sign bit, or an equivalent correct signed scheme is used.
  - When N2_W is not a multiple of STEP_W, the final chunk is sign-extended.
- FSM states:
  - IDLE: on i_start_pls=1, capture operands, clear the accumulator, go to MULT.
  - MULT: stays for exactly ITER cycles, then goes to FMT.
  - FMT: 1 cycle; round, saturate/wrap, register o_res/o_ovf_flag, pulse o_done_pls, return to IDLE.
- Latency: if i_start_pls is high in cycle 0, o_done_pls is high in cycle ITER+1 (defaults: cycle 7).
- o_busy: high in cycles 1..ITER+1 inclusive, low otherwise.
- i_start_pls is ignored while o_busy=1, including the done cycle. A start in cycle ITER+2 (the first cycle after done) is accepted.
- Fraction conversion:
  - RES_FRACT_W >= product FRACT: append zeros.
  - Otherwise, apply ROUND_MODE to the dropped bits. A rounding carry propagates into the integer part before the overflow check.
- Integer conversion:
  - RES_INT_W >= product INT (plus one if rounding can carry): sign-extend.
  - Otherwise, detect whether the value lies outside [-2^(RES_INT_W-1), 2^(RES_INT_W-1) - 2^-RES_FRACT_W].
  - On overflow: SAT_EN=1 gives max (0 followed by all ones) or min (1 followed by all zeros) by sign. SAT_EN=0 keeps the low RES_W bits.
  - o_ovf_flag=1 in both cases.
- Precision loss from rounding alone does not set o_ovf_flag.
- o_res and o_ovf_flag change only in the o_done_pls cycle.

Test Plan:
1. Defaults (Q1.5 x Q1.5 -> Q2.10): num1=0x10 (0.5), num2=0x30 (-0.5), start at cycle 0 -> o_busy high cycles 1..7, done at cycle 7, o_res=0xF00 (-0.25), ovf=0.
2. Defaults, corner case: num1=0x20, num2=0x20 (-1 x -1) -> o_res=0x400 (+1.0), ovf=0. Repeat with STEP_W=4 (ITER=2): same result, done at cycle 3.
3. RES_INT_W=1, RES_FRACT_W=5, num1=num2=0x20 -> SAT_EN=1: o_res=0x1F, ovf=1. SAT_EN=0: o_res=0x20, ovf=1.
4. RES_INT_W=2, RES_FRACT_W=5:
   - num1=0x01, num2=0x10 (+1/64): ROUND_MODE=0 gives o_res=0x00, ROUND_MODE=1 gives 0x01.
   - num1=0x3F, num2=0x10 (-1/64): ROUND_MODE=0 gives 0x7F, ROUND_MODE=1 gives 0x00.
   - All cases ovf=0.
5. Defaults: start at cycle 0, second start at cycles 3 and 7 -> exactly one done at cycle 7 with the first result. A start at cycle 8 gives done at cycle 15.
6. Defaults: start at cycle 0, rstn low at cycle 4 -> outputs 0 immediately, no done ever. After release, a new start completes normally with the correct o_res.
